// File: rtl/div_arbiter_pkg.sv
// div_arb_pkg
// Shared definitions for the divider arbiter slice:
//   DEF_W / DEF_NREQ : default operand width and requester count
//   state_t          : arbiter FSM states (IDLE, RUN, RESP)
//   DIV0_QUOTIENT    : quotient reported for a zero divisor (all ones)
package div_arb_pkg;

    localparam int DEF_W    = 16;
    localparam int DEF_NREQ = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [DEF_W-1:0] DIV0_QUOTIENT = {DEF_W{1'b1}};

endpackage

// File: rtl/div_arbiter_core.sv
// div_core
// Unsigned restoring divider, one quotient bit per clock, MSB first.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : load dividend/divisor and begin W iterations
//   dividend   : W-bit dividend (sampled only with start)
//   divisor    : W-bit divisor (sampled only with start, must be nonzero)
//   done       : one-cycle pulse, quotient/remainder final
//   quotient   : W-bit quotient
//   remainder  : W-bit remainder
// The cycle after start is the first iteration; done is high in the cycle
// following the W-th iteration.
module div_core
    import div_arb_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CW = $clog2(W + 1);

    // dq holds the not-yet-consumed dividend bits at the top and the
    // quotient bits shifted in at the bottom.
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  dq_q, dq_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;
    logic [W:0]    trial;

    always_comb begin
        rem_d = rem_q;
        dq_d  = dq_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        run_d = run_q;
        trial = {rem_q, dq_q[W-1]} - {1'b0, dvs_q};

        if (start) begin
            rem_d = '0;
            dq_d  = dividend;
            dvs_d = divisor;
            cnt_d = CW'(W);
            run_d = 1'b1;
        end else if (run_q) begin
            if (cnt_q != '0) begin
                // Sign bit of the W+1 bit trial decides restore vs keep.
                if (!trial[W]) begin
                    rem_d = trial[W-1:0];
                    dq_d  = {dq_q[W-2:0], 1'b1};
                end else begin
                    rem_d = {rem_q[W-2:0], dq_q[W-1]};
                    dq_d  = {dq_q[W-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
            end else begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            dq_q  <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            dq_q  <= dq_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign done      = run_q && (cnt_q == '0);
    assign quotient  = dq_q;
    assign remainder = rem_q;

endmodule

// File: rtl/div_arbiter.sv
// div_arbiter
// Round-robin sharing of one sequential divider between NREQ requesters.
//   clk, rst     : clock, asynchronous active-high reset
//   req          : per-requester request, held with operands until ack
//   dividend_in  : packed dividends, requester i at [i*W +: W]
//   divisor_in   : packed divisors, same packing
//   ack          : one-hot one-cycle pulse, operands of requester captured
//   busy         : divider owned (state not IDLE)
//   resp_valid   : one-cycle pulse, result outputs valid
//   resp_id      : requester owning the result
//   quotient     : result quotient, held until next resp_valid
//   remainder    : result remainder, held until next resp_valid
//   div0         : divisor was zero, held with the result
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] dividend_in,
    input  logic [NREQ*W-1:0] divisor_in,
    output logic [NREQ-1:0]   ack,
    output logic              busy,
    output logic              resp_valid,
    output logic [IDW-1:0]    resp_id,
    output logic [W-1:0]      quotient,
    output logic [W-1:0]      remainder,
    output logic              div0
);

    localparam logic [W-1:0] DIV0_Q = W'($signed(DIV0_QUOTIENT));

    // Unpacked views of the operand buses.
    logic [W-1:0] dvd_arr [NREQ];
    logic [W-1:0] dvs_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign dvd_arr[gi] = dividend_in[gi*W +: W];
            assign dvs_arr[gi] = divisor_in[gi*W +: W];
        end
    endgenerate

    state_t          state_q, state_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            resp_valid_q, resp_valid_d;
    logic [IDW-1:0]  resp_id_q, resp_id_d;
    logic [W-1:0]    quot_q, quot_d;
    logic [W-1:0]    rem_q, rem_d;
    logic            div0_q, div0_d;
    logic            zero_pend_q, zero_pend_d;
    logic [W-1:0]    dvd_cap_q, dvd_cap_d;

    logic            grant_vld;
    logic [IDW-1:0]  grant_idx;
    logic            core_start;
    logic            core_done;
    logic [W-1:0]    core_quot;
    logic [W-1:0]    core_rem;

    // Round-robin search starting just after the last winner.
    always_comb begin
        int             idx;
        logic [IDW-1:0] idx_v;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        idx_v     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_v = IDW'(idx);
            if (!grant_vld && req[idx_v]) begin
                grant_vld = 1'b1;
                grant_idx = idx_v;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        owner_d      = owner_q;
        ack_d        = '0;
        resp_valid_d = 1'b0;
        resp_id_d    = resp_id_q;
        quot_d       = quot_q;
        rem_d        = rem_q;
        div0_d       = div0_q;
        zero_pend_d  = zero_pend_q;
        dvd_cap_d    = dvd_cap_q;
        core_start   = 1'b0;

        case (state_q)
            // RESP lasts one cycle and its closing edge doubles as an
            // arbitration edge, so back-to-back operations repeat every
            // W+2 cycles.
            IDLE, RESP: begin
                state_d = IDLE;
                if (grant_vld) begin
                    state_d          = RUN;
                    last_d           = grant_idx;
                    owner_d          = grant_idx;
                    ack_d[grant_idx] = 1'b1;
                    dvd_cap_d        = dvd_arr[grant_idx];
                    zero_pend_d      = (dvs_arr[grant_idx] == '0);
                    // A zero divisor never starts the core; RUN turns it
                    // straight into a RESP one cycle later.
                    core_start       = (dvs_arr[grant_idx] != '0);
                end
            end
            RUN: begin
                if (zero_pend_q) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_id_d    = owner_q;
                    quot_d       = DIV0_Q;
                    rem_d        = dvd_cap_q;
                    div0_d       = 1'b1;
                end else if (core_done) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_id_d    = owner_q;
                    quot_d       = core_quot;
                    rem_d        = core_rem;
                    div0_d       = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_q       <= IDW'(NREQ - 1);
            owner_q      <= '0;
            ack_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            quot_q       <= '0;
            rem_q        <= '0;
            div0_q       <= 1'b0;
            zero_pend_q  <= 1'b0;
            dvd_cap_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            owner_q      <= owner_d;
            ack_q        <= ack_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            quot_q       <= quot_d;
            rem_q        <= rem_d;
            div0_q       <= div0_d;
            zero_pend_q  <= zero_pend_d;
            dvd_cap_q    <= dvd_cap_d;
        end
    end

    div_core #(
        .W (W)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .start     (core_start),
        .dividend  (dvd_arr[grant_idx]),
        .divisor   (dvs_arr[grant_idx]),
        .done      (core_done),
        .quotient  (core_quot),
        .remainder (core_rem)
    );

    assign ack        = ack_q;
    assign busy       = (state_q != IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign quotient   = quot_q;
    assign remainder  = rem_q;
    assign div0       = div0_q;

endmodule
